// File: rtl/hazard_unit.sv
// Stall/flush controller for the 5-stage RV32 pipeline: load-use interlock, redirect flush, multi-cycle wait.
// Optional HU_PERF_CNT_EN macro adds 32-bit load-use / flush-entry / multi-cycle-wait event counters.
module hazard_unit #(
    parameter int AWIDTH       = 5,
    parameter int FLUSH_CYCLES = 2,
    parameter int MC_TIMEOUT   = 64
) (
    input  logic              hu_clk,
    input  logic              hu_rst,
    input  logic              hu_i_ds_valid,
    input  logic [AWIDTH-1:0] hu_i_ds_rs1,
    input  logic [AWIDTH-1:0] hu_i_ds_rs2,
    input  logic              hu_i_ds_use_rs2,
    input  logic              hu_i_ex_valid,
    input  logic              hu_i_ex_is_load,
    input  logic [AWIDTH-1:0] hu_i_ex_rd,
    input  logic              hu_i_redirect,
    input  logic              hu_i_mc_start,
    input  logic              hu_i_mc_done,
    output logic              hu_o_fs_stall,
    output logic              hu_o_ds_stall,
    output logic              hu_o_ds_flush,
    output logic              hu_o_es_stall,
    output logic              hu_o_es_flush,
    output logic              hu_o_timeout,
    output logic [1:0]        hu_o_state
`ifdef HU_PERF_CNT_EN
    ,
    output logic [31:0]       hu_o_lu_cnt,
    output logic [31:0]       hu_o_flush_cnt,
    output logic [31:0]       hu_o_mc_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_FLUSH   = 2'd1,
        ST_MC_WAIT = 2'd2
    } state_t;

    localparam logic [3:0] FLUSH_LOAD        = 4'(FLUSH_CYCLES - 1);
    localparam logic [3:0] FLUSH_FULL        = 4'(FLUSH_CYCLES);
    localparam logic [9:0] MC_LAST           = 10'(MC_TIMEOUT - 1);
    localparam bit         REDIRECT_TO_FLUSH = (FLUSH_CYCLES > 1);

    state_t     state, state_nxt;
    logic [3:0] flush_cnt, flush_cnt_nxt;
    logic [9:0] mc_cnt, mc_cnt_nxt;

    logic lu_hit;
    logic fs_stall, ds_stall, ds_flush, es_stall, es_flush, timeout;
    logic lu_stall, flush_entry;

    assign lu_hit = hu_i_ex_valid & hu_i_ex_is_load & hu_i_ds_valid &
                    (hu_i_ex_rd != '0) &
                    ((hu_i_ex_rd == hu_i_ds_rs1) |
                     (hu_i_ds_use_rs2 & (hu_i_ex_rd == hu_i_ds_rs2)));

    always_ff @(posedge hu_clk or negedge hu_rst) begin
        if (!hu_rst) begin
            state     <= ST_RUN;
            flush_cnt <= '0;
            mc_cnt    <= '0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_cnt_nxt;
            mc_cnt    <= mc_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        flush_cnt_nxt = flush_cnt;
        mc_cnt_nxt    = mc_cnt;
        fs_stall      = 1'b0;
        ds_stall      = 1'b0;
        ds_flush      = 1'b0;
        es_stall      = 1'b0;
        es_flush      = 1'b0;
        timeout       = 1'b0;
        lu_stall      = 1'b0;
        flush_entry   = 1'b0;
        case (state)
            ST_RUN: begin
                if (hu_i_redirect) begin
                    ds_flush      = 1'b1;
                    es_flush      = 1'b1;
                    flush_cnt_nxt = FLUSH_LOAD;
                    if (REDIRECT_TO_FLUSH) begin
                        state_nxt   = ST_FLUSH;
                        flush_entry = 1'b1;
                    end
                end else if (hu_i_mc_start) begin
                    // A start that completes in the same cycle behaves like a single-cycle op.
                    if (!hu_i_mc_done) begin
                        fs_stall   = 1'b1;
                        ds_stall   = 1'b1;
                        es_stall   = 1'b1;
                        mc_cnt_nxt = '0;
                        state_nxt  = ST_MC_WAIT;
                    end
                end else if (lu_hit) begin
                    fs_stall = 1'b1;
                    ds_stall = 1'b1;
                    es_flush = 1'b1;
                    lu_stall = 1'b1;
                end
            end
            ST_FLUSH: begin
                ds_flush = 1'b1;
                es_flush = 1'b1;
                if (hu_i_redirect) begin
                    flush_cnt_nxt = FLUSH_LOAD;
                end else if (flush_cnt <= 4'd1) begin
                    flush_cnt_nxt = '0;
                    state_nxt     = ST_RUN;
                end else begin
                    flush_cnt_nxt = flush_cnt - 4'd1;
                end
            end
            ST_MC_WAIT: begin
                if (hu_i_mc_done) begin
                    state_nxt = ST_RUN;
                end else begin
                    fs_stall = 1'b1;
                    ds_stall = 1'b1;
                    es_stall = 1'b1;
                    if (mc_cnt >= MC_LAST) begin
                        // Timeout has no redirect cycle of its own, so FLUSH runs the full count.
                        timeout       = 1'b1;
                        ds_flush      = 1'b1;
                        es_flush      = 1'b1;
                        flush_cnt_nxt = FLUSH_FULL;
                        state_nxt     = ST_FLUSH;
                        flush_entry   = 1'b1;
                    end else begin
                        mc_cnt_nxt = mc_cnt + 10'd1;
                    end
                end
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    assign hu_o_fs_stall = hu_rst & fs_stall;
    assign hu_o_ds_stall = hu_rst & ds_stall;
    assign hu_o_ds_flush = hu_rst & ds_flush;
    assign hu_o_es_stall = hu_rst & es_stall;
    assign hu_o_es_flush = hu_rst & es_flush;
    assign hu_o_timeout  = hu_rst & timeout;
    assign hu_o_state    = state;

`ifdef HU_PERF_CNT_EN
    logic [31:0] perf_lu, perf_flush, perf_mc;

    always_ff @(posedge hu_clk or negedge hu_rst) begin
        if (!hu_rst) begin
            perf_lu    <= '0;
            perf_flush <= '0;
            perf_mc    <= '0;
        end else begin
            if (lu_stall)
                perf_lu <= perf_lu + 32'd1;
            if (flush_entry)
                perf_flush <= perf_flush + 32'd1;
            if (state == ST_MC_WAIT)
                perf_mc <= perf_mc + 32'd1;
        end
    end

    assign hu_o_lu_cnt    = perf_lu;
    assign hu_o_flush_cnt = perf_flush;
    assign hu_o_mc_cnt    = perf_mc;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed, table-driven bench for hazard_unit (FLUSH_CYCLES=2, MC_TIMEOUT=8).
module tb_hazard_unit;

    localparam int AW = 5;

    // Expected output patterns: {fs_stall, ds_stall, ds_flush, es_stall, es_flush, timeout}
    localparam logic [5:0] O_NONE = 6'b000000;
    localparam logic [5:0] O_LU   = 6'b110010;
    localparam logic [5:0] O_FL   = 6'b001010;
    localparam logic [5:0] O_MC   = 6'b110100;
    localparam logic [5:0] O_TO   = 6'b111111;

    typedef struct {
        logic          dv;
        logic [AW-1:0] rs1;
        logic [AW-1:0] rs2;
        logic          u2;
        logic          ev;
        logic          ld;
        logic [AW-1:0] rd;
        logic          rdr;
        logic          ms;
        logic          md;
        logic [5:0]    exp_o;
        logic [1:0]    exp_st;
    } vec_t;

    logic          clk;
    logic          rst_n;
    logic          ds_valid, ds_use_rs2, ex_valid, ex_is_load, redirect, mc_start, mc_done;
    logic [AW-1:0] ds_rs1, ds_rs2, ex_rd;
    logic          fs_stall, ds_stall, ds_flush, es_stall, es_flush, timeout;
    logic [1:0]    state;
`ifdef HU_PERF_CNT_EN
    logic [31:0]   lu_cnt, flush_cnt, mc_cnt;
`endif

    int tests;
    int failures;
    vec_t tbl[24];

    hazard_unit #(.AWIDTH(AW), .FLUSH_CYCLES(2), .MC_TIMEOUT(8)) dut (
        .hu_clk(clk),
        .hu_rst(rst_n),
        .hu_i_ds_valid(ds_valid),
        .hu_i_ds_rs1(ds_rs1),
        .hu_i_ds_rs2(ds_rs2),
        .hu_i_ds_use_rs2(ds_use_rs2),
        .hu_i_ex_valid(ex_valid),
        .hu_i_ex_is_load(ex_is_load),
        .hu_i_ex_rd(ex_rd),
        .hu_i_redirect(redirect),
        .hu_i_mc_start(mc_start),
        .hu_i_mc_done(mc_done),
        .hu_o_fs_stall(fs_stall),
        .hu_o_ds_stall(ds_stall),
        .hu_o_ds_flush(ds_flush),
        .hu_o_es_stall(es_stall),
        .hu_o_es_flush(es_flush),
        .hu_o_timeout(timeout),
        .hu_o_state(state)
`ifdef HU_PERF_CNT_EN
        ,
        .hu_o_lu_cnt(lu_cnt),
        .hu_o_flush_cnt(flush_cnt),
        .hu_o_mc_cnt(mc_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic dv, logic [AW-1:0] rs1, logic [AW-1:0] rs2, logic u2,
                                logic ev, logic ld, logic [AW-1:0] rd,
                                logic rdr, logic ms, logic md,
                                logic [5:0] exp_o, logic [1:0] exp_st);
        vec_t v;
        v.dv = dv; v.rs1 = rs1; v.rs2 = rs2; v.u2 = u2;
        v.ev = ev; v.ld = ld; v.rd = rd;
        v.rdr = rdr; v.ms = ms; v.md = md;
        v.exp_o = exp_o; v.exp_st = exp_st;
        return v;
    endfunction

    function automatic vec_t idle(logic [5:0] exp_o, logic [1:0] exp_st);
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, exp_o, exp_st);
    endfunction

    task automatic drive(input vec_t v);
        ds_valid   = v.dv;
        ds_rs1     = v.rs1;
        ds_rs2     = v.rs2;
        ds_use_rs2 = v.u2;
        ex_valid   = v.ev;
        ex_is_load = v.ld;
        ex_rd      = v.rd;
        redirect   = v.rdr;
        mc_start   = v.ms;
        mc_done    = v.md;
    endtask

    // One cycle: drive just after the rising edge, sample mid-cycle.
    task automatic applyStimulus(input vec_t v);
        @(posedge clk);
        #1;
        drive(v);
        #3;
    endtask

    task automatic checkOutput(input string name, input vec_t v);
        logic [5:0] act;
        act = {fs_stall, ds_stall, ds_flush, es_stall, es_flush, timeout};
        tests++;
        if (act !== v.exp_o || state !== v.exp_st) begin
            failures++;
            $display("[TB] FAIL %s: got out=%b state=%0d, expected out=%b state=%0d",
                     name, act, state, v.exp_o, v.exp_st);
        end
    endtask

    task automatic checkCount(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    initial begin
        tests    = 0;
        failures = 0;

        tbl[0]  = mk(1, 5, 0, 0, 1, 1, 5, 0, 0, 0, O_LU,   0);
        tbl[1]  = idle(O_NONE, 0);
        tbl[2]  = mk(1, 0, 0, 0, 1, 1, 0, 0, 0, 0, O_NONE, 0);
        tbl[3]  = mk(1, 3, 5, 0, 1, 1, 5, 0, 0, 0, O_NONE, 0);
        tbl[4]  = mk(1, 3, 5, 1, 1, 1, 5, 0, 0, 0, O_LU,   0);
        tbl[5]  = mk(1, 3, 5, 1, 1, 0, 5, 0, 0, 0, O_NONE, 0);
        tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, O_FL,   0);
        tbl[7]  = idle(O_FL, 1);
        tbl[8]  = idle(O_NONE, 0);
        tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, O_FL,   0);
        tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, O_FL,   1);
        tbl[11] = idle(O_FL, 1);
        tbl[12] = idle(O_NONE, 0);
        tbl[13] = mk(1, 5, 0, 0, 1, 1, 5, 1, 1, 0, O_FL,   0);
        tbl[14] = mk(1, 5, 0, 0, 1, 1, 5, 0, 1, 0, O_FL,   1);
        tbl[15] = idle(O_NONE, 0);
        tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, O_NONE, 0);
        tbl[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_MC,   0);
        tbl[18] = idle(O_MC, 2);
        tbl[19] = mk(1, 7, 0, 0, 1, 1, 7, 1, 0, 0, O_MC,   2);
        tbl[20] = idle(O_MC, 2);
        tbl[21] = idle(O_MC, 2);
        tbl[22] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, O_NONE, 2);
        tbl[23] = idle(O_NONE, 0);

        // Reset held with a redirect pending: everything must read zero.
        rst_n = 1'b0;
        drive(mk(1, 5, 0, 0, 1, 1, 5, 1, 0, 0, O_NONE, 0));
        #2;
        checkOutput("reset_hold", idle(O_NONE, 0));
        @(negedge clk);
        drive(idle(O_NONE, 0));
        rst_n = 1'b1;

        for (int i = 0; i < 24; i++) begin
            applyStimulus(tbl[i]);
            checkOutput($sformatf("row%0d", i), tbl[i]);
        end

`ifdef HU_PERF_CNT_EN
        checkCount("perf_lu", lu_cnt, 32'd2);
        checkCount("perf_flush", flush_cnt, 32'd3);
        checkCount("perf_mc", mc_cnt, 32'd5);
`endif

        // Timeout: start never completes, pulse on the 8th cycle after start.
        applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_MC, 0));
        checkOutput("to_start", mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_MC, 0));
        for (int k = 1; k < 8; k++) begin
            applyStimulus(idle(O_MC, 2));
            checkOutput($sformatf("to_wait%0d", k), idle(O_MC, 2));
        end
        applyStimulus(idle(O_TO, 2));
        checkOutput("to_pulse", idle(O_TO, 2));
        applyStimulus(idle(O_FL, 1));
        checkOutput("to_flush1", idle(O_FL, 1));
        applyStimulus(idle(O_FL, 1));
        checkOutput("to_flush2", idle(O_FL, 1));
        applyStimulus(idle(O_NONE, 0));
        checkOutput("to_run", idle(O_NONE, 0));

        // Asynchronous reset in the middle of MC_WAIT.
        applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_MC, 0));
        checkOutput("rst_mc_start", mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_MC, 0));
        applyStimulus(idle(O_MC, 2));
        checkOutput("rst_mc_wait", idle(O_MC, 2));
        rst_n = 1'b0;
        drive(mk(1, 5, 0, 0, 1, 1, 5, 1, 0, 0, O_NONE, 0));
        #1;
        checkOutput("rst_async", idle(O_NONE, 0));
`ifdef HU_PERF_CNT_EN
        checkCount("perf_mc_rst", mc_cnt, 32'd0);
`endif
        @(negedge clk);
        drive(idle(O_NONE, 0));
        rst_n = 1'b1;
        applyStimulus(idle(O_NONE, 0));
        checkOutput("rst_release", idle(O_NONE, 0));

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
